adder_req_driver: RTL
=====================

// Module: adder_req_driver
// PURPOSE
//  Sequential driver for the driver side of the intf adder interface: drives a, b and samples c.
//  - Accepts operand requests on a valid/ready port and drives them onto intf a/b.
//  - Waits a fixed settle time, then samples c and checks it against an internal a+b.
//  - Returns sum plus a mismatch flag on a valid/ready response port, and keeps txn/error counters.
//  - Sits between a stimulus source and any intf.dut-side block (e.g. the adder).
// PARAMETERS
//  SETTLE_CYCLES  1  clock edges between driving a/b and sampling c; must be >=1 (elab-time assertion)
//  CNT_W          8  width of txn_count and err_count
// PORTS
//  clk          input   1      clock; all state updates on posedge
//  rst          input   1      synchronous, active-high reset
//  bus          modport intf.driver  outputs a[3:0], b[3:0]; input c[4:0]
//  req_valid    input   1      request operands valid
//  req_ready    output  1      driver can accept a request
//  req_a        input   4      operand a
//  req_b        input   4      operand b
//  rsp_valid    output  1      response valid
//  rsp_ready    input   1      consumer accepts response
//  rsp_sum      output  5      c sampled from bus
//  rsp_err      output  1      1 = sampled c != {1'b0,a}+{1'b0,b}
//  txn_count    output  CNT_W  completed responses, wraps modulo 2^CNT_W
//  err_count    output  CNT_W  responses with rsp_err=1, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst high at posedge):
//    state=IDLE; bus.a=0, bus.b=0; rsp_sum=0, rsp_err=0, rsp_valid=0.
//    txn_count=0, err_count=0; req_ready=1 in the cycle after reset.
//    rst has priority over every other event.
//  - FSM states IDLE, SETTLE, RESP. All outputs are registered or decoded from state.
//  - IDLE: req_ready=1, rsp_valid=0.
//    On req_valid&&req_ready at edge E0:
//      latch req_a/req_b into bus.a/bus.b; settle counter = SETTLE_CYCLES-1; go SETTLE.
//  - SETTLE: req_ready=0.
//    Each edge: if counter==0, sample c into rsp_sum, set rsp_err=(c!={1'b0,a}+{1'b0,b}), go RESP.
//    Otherwise decrement the counter.
//    Sampling happens at edge E0+SETTLE_CYCLES, so a/b are stable for SETTLE_CYCLES full cycles.
//  - RESP: rsp_valid=1; rsp_sum/rsp_err held stable until the handshake.
//    On rsp_valid&&rsp_ready: txn_count+=1 (wraps), err_count+=rsp_err (saturates), go IDLE.
//    Next request is accepted no earlier than the following edge.
//  - Latency: rsp_valid rises SETTLE_CYCLES edges after the accept edge.
//    Peak throughput is one txn per SETTLE_CYCLES+2 cycles.
//  - bus.a/bus.b keep the last driven values between transactions (no return to 0); change only on accept.
//  - Arithmetic: expected sum is 5-bit zero-extended; carry out is bit 4, no overflow possible.
//  - rsp_ready held low: stay in RESP indefinitely; no new request accepted; bus values unchanged.
//  - req_valid high while not in IDLE: ignored (req_ready=0), operands not sampled.
//  - rst mid-SETTLE or mid-RESP: pending txn dropped, no counter update, bus returns to 0.
// STRUCTURE
//  - Package adder_drv_pkg:
//    typedef enum logic [1:0] {IDLE, SETTLE, RESP} drv_state_t;
//    localparam OP_W=4, SUM_W=5 (must match intf widths).
//  - One sub-module drv_settle_timer (load/count-down/done, width $clog2(SETTLE_CYCLES+1)).
//  - FSM, datapath and counters stay in adder_req_driver.
// TESTING (bench: intf instance, adder on i1.dut, this block on i1.driver)
//  1. rst 2 cycles -> bus.a=0, bus.b=0, rsp_valid=0, req_ready=1, counters 0.
//  2. req a=6,b=4, rsp_ready=1, SETTLE_CYCLES=1 -> rsp_valid 1 edge after accept, rsp_sum=10, rsp_err=0, txn_count=1.
//  3. a=15,b=15 -> rsp_sum=30 (5'b11110), rsp_err=0; SETTLE_CYCLES=3 -> rsp_valid 3 edges after accept.
//  4. rsp_ready low 5 cycles with new req_valid pending -> rsp_sum stable, req_ready=0, no new accept; accepted after handshake.
//  5. force bus.c=0 with a=3,b=2 -> rsp_err=1, err_count=1; 300 faulty txns -> err_count=255 (saturated).
//  6. rst asserted while in SETTLE -> no rsp_valid, txn_count unchanged, bus.a=bus.b=0; 256 good txns -> txn_count wraps to 0.

Source files
------------

// File: rtl/adder_drv_pkg.sv
// Shared types and widths for the adder request driver.
// Operand/sum widths must match the intf bus.
package adder_drv_pkg;

    localparam int OP_W  = 4;
    localparam int SUM_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } drv_state_t;

    // Zero-extended sum; bit 4 holds the carry, so it cannot overflow.
    function automatic logic [SUM_W-1:0] ref_sum(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_req_driver_if.sv
// Adder bus: the driver drives a/b, the dut side returns c.
// The driver side reads c back for checking.
interface intf;
    import adder_drv_pkg::*;

    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [SUM_W-1:0] c;

    modport driver (
        output a,
        output b,
        input  c
    );

    modport dut (
        input  a,
        input  b,
        output c
    );

endinterface

// File: rtl/adder_req_driver_settle_timer.sv
// Down-counter that times how long a/b settle before c is sampled.
// Loads SETTLE_CYCLES-1 on accept; done flags the sampling edge.
module drv_settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] cnt;

    // Load on accept, then count down while the driver is settling.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/adder_req_driver.sv
// Drives operand requests onto the adder bus, samples c after a
// settle time and returns the sum with a mismatch flag.
module adder_req_driver
    import adder_drv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    intf.driver              bus,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_a,
    input  logic [OP_W-1:0]  req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [SUM_W-1:0] rsp_sum,
    output logic             rsp_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [CNT_W-1:0] err_count
);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end

    drv_state_t state;
    drv_state_t state_nxt;

    logic accept;
    logic deliver;
    logic settle_done;
    logic in_settle;

    assign accept    = req_valid && req_ready;
    assign deliver   = rsp_valid && rsp_ready;
    assign in_settle = (state == SETTLE);

    drv_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .en   (in_settle),
        .done (settle_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)      state_nxt = SETTLE;
            SETTLE:  if (settle_done) state_nxt = RESP;
            RESP:    if (deliver)     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operands hold their last value between transactions.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.a <= '0;
            bus.b <= '0;
        end else if (accept) begin
            bus.a <= req_a;
            bus.b <= req_b;
        end
    end

    // Capture c once settled; held until the response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_sum <= '0;
            rsp_err <= 1'b0;
        end else if (in_settle && settle_done) begin
            rsp_sum <= bus.c;
            rsp_err <= (bus.c != ref_sum(bus.a, bus.b));
        end
    end

    // txn_count wraps; err_count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count <= '0;
            err_count <= '0;
        end else if (deliver) begin
            txn_count <= txn_count + 1'b1;
            if (rsp_err && err_count != '1) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
